iscas_bist_ctrl: RTL and testbench



---
 rtl/iscas_bist_ctrl.sv | 140 ++++++++++++++
 tb/tb_iscas_bist_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iscas_bist_ctrl.sv
// Logic BIST sequencer for a small combinational CUT: drives exhaustive or LFSR
// patterns, compacts the responses in a MISR and compares against a golden signature.
module iscas_bist_ctrl #(
  parameter int unsigned           N_IN      = 5,
  parameter int unsigned           N_OUT     = 2,
  parameter int unsigned           SETTLE    = 1,
  parameter int unsigned           MISR_W    = 16,
  parameter logic [MISR_W-1:0]     MISR_POLY = 16'h8016,
  parameter logic [N_IN-1:0]       LFSR_POLY = 5'h12,
  parameter logic [MISR_W-1:0]     GOLDEN    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [N_OUT-1:0]  resp_in,
  output logic [N_IN-1:0]   pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [N_IN:0]     pat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] PAT_SEED    = N_IN'(1);

  state_t              state_q, state_d;
  logic [N_IN-1:0]     pat_q, pat_d;
  logic [MISR_W-1:0]   sig_q, sig_d;
  logic [N_IN:0]       cnt_q, cnt_d;
  logic [3:0]          settle_q, settle_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [N_IN-1:0]     pat_lfsr;
  logic [N_IN-1:0]     pat_inc;
  logic [N_IN-1:0]     pat_adv;
  logic                last_pat;
  logic                settle_last;
  logic [MISR_W-1:0]   resp_ext;
  logic [MISR_W-1:0]   sig_upd;

  always_comb begin
    pat_lfsr    = (pat_q >> 1) ^ (pat_q[0] ? LFSR_POLY : '0);
    pat_inc     = pat_q + PAT_SEED;
    pat_adv     = mode_q ? pat_lfsr : pat_inc;
    // LFSR run ends on the state that would wrap back to the seed
    last_pat    = mode_q ? (pat_lfsr == PAT_SEED) : (&pat_q);
    settle_last = (settle_q == SETTLE_LAST);
    resp_ext    = MISR_W'(resp_in);
    sig_upd     = {sig_q[MISR_W-2:0], 1'b0}
                ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                ^ resp_ext;
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          pat_d    = mode ? PAT_SEED : '0;
          sig_d    = '0;
          cnt_d    = '0;
          settle_d = '0;
          mode_d   = mode;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      S_APPLY: begin
        if (settle_last) begin
          settle_d = '0;
          sig_d    = sig_upd;
          cnt_d    = cnt_q + (N_IN+1)'(1);
          if (last_pat) begin
            state_d = S_DONE;
            pat_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pat_d = pat_adv;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pat_out   = pat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign pass      = done_q && (sig_q == GOLDEN);

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Directed bench for iscas_bist_ctrl driving a c17 model as the CUT; expected
// patterns are queued at start and popped as the DUT applies them.
module tb_iscas_bist_ctrl;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h8016 : 16'h0000) ^ {14'h0, r};
  endfunction

  function automatic logic [4:0] lfsr(input logic [4:0] p);
    return (p >> 1) ^ (p[0] ? 5'h12 : 5'h00);
  endfunction

  function automatic logic [15:0] gold_sig();
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < 32; i++) s = misr(s, c17(5'(i)));
    return s;
  endfunction

  localparam logic [15:0] GOLD = gold_sig();

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, mode_a, start_b, mode_b, inj;
  logic [1:0]  resp_a, resp_b;
  logic [4:0]  pat_a, pat_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;
  logic [5:0]  cnt_a, cnt_b;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [4:0]  sb_q[$];

  always #5 clk = ~clk;

  assign resp_a = c17(pat_a) ^ {1'b0, inj && (pat_a == 5'd13)};
  assign resp_b = c17(pat_b);

  iscas_bist_ctrl #(.N_IN(5), .N_OUT(2), .SETTLE(1), .MISR_W(16),
                    .MISR_POLY(16'h8016), .LFSR_POLY(5'h12), .GOLDEN(GOLD)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .resp_in(resp_a),
    .pat_out(pat_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a));

  iscas_bist_ctrl #(.N_IN(5), .N_OUT(2), .SETTLE(3), .MISR_W(16),
                    .MISR_POLY(16'h8016), .LFSR_POLY(5'h12), .GOLDEN(GOLD)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .resp_in(resp_b),
    .pat_out(pat_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_pat"},  32'(pat_a),  32'h0);
    check({tag, "_busy"}, 32'(busy_a), 32'h0);
    check({tag, "_done"}, 32'(done_a), 32'h0);
    check({tag, "_pass"}, 32'(pass_a), 32'h0);
    check({tag, "_sig"},  32'(sig_a),  32'h0);
    check({tag, "_cnt"},  32'(cnt_a),  32'h0);
  endtask

  // One run on dut_a; rst_at/kick_at select the pattern index for a reset or a stray start (-1 = none)
  task automatic run_a(input logic m, input logic fault, input int rst_at, input int kick_at);
    logic [4:0]  p, e;
    logic [15:0] s;
    logic [31:0] seen;
    int          n;
    sb_q.delete();
    p = m ? 5'h01 : 5'h00;
    s = 16'h0;
    n = m ? 31 : 32;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(p);
      s = misr(s, c17(p) ^ {1'b0, fault && (p == 5'd13)});
      p = m ? lfsr(p) : p + 5'd1;
    end
    mode_a = m;
    inj    = fault;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_sig",  32'(sig_a),  32'h0);
    check("start_cnt",  32'(cnt_a),  32'h0);
    check("start_busy", 32'(busy_a), 32'h1);
    check("start_done", 32'(done_a), 32'h0);
    seen = 32'h0;
    for (int i = 0; i < n; i++) begin
      e = sb_q.pop_front();
      check("pat", 32'(pat_a), 32'(e));
      if (m) begin
        check("lfsr_nonzero", 32'(pat_a != 5'h00), 32'h1);
        check("lfsr_distinct", 32'(seen[pat_a]), 32'h0);
        seen[pat_a] = 1'b1;
      end
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 check_zero_a("rst_async");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (i == kick_at) start_a = 1'b1;
      tick();
      start_a = 1'b0;
      if (i < n - 1) check("done_early", 32'(done_a), 32'h0);
    end
    check("end_done", 32'(done_a), 32'h1);
    check("end_busy", 32'(busy_a), 32'h0);
    check("end_pat",  32'(pat_a),  32'h0);
    check("end_cnt",  32'(cnt_a),  32'(n));
    check("end_sig",  32'(sig_a),  32'(s));
    check("end_pass", 32'(pass_a), 32'(s == GOLD));
    if (fault) check("fault_sig_differs", 32'(sig_a !== GOLD), 32'h1);
    repeat (3) tick();
    check("hold_done", 32'(done_a), 32'h1);
    check("hold_sig",  32'(sig_a),  32'(s));
    check("hold_cnt",  32'(cnt_a),  32'(n));
    check("hold_pass", 32'(pass_a), 32'(s == GOLD));
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0; inj = 1'b0;
    repeat (2) tick();
    check_zero_a("reset");
    check("reset_b_pat",  32'(pat_b),  32'h0);
    check("reset_b_busy", 32'(busy_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_a(1'b0, 1'b0, -1, -1);          // exhaustive, golden signature
    run_a(1'b0, 1'b1, -1, -1);          // restart from DONE, fault on pattern 13
    run_a(1'b0, 1'b0, -1, 5);           // stray start mid-run
    run_a(1'b1, 1'b0, -1, -1);          // LFSR sequence
    run_a(1'b0, 1'b0, 10, -1);          // reset at pattern 10
    tick();
    check_zero_a("post_rst");
    run_a(1'b0, 1'b0, -1, -1);          // fresh run after abort

    // SETTLE=3: each pattern held three cycles, capture only on the third
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 3; k++) begin
        check("s3_pat", 32'(pat_b), 32'(i));
        check("s3_cnt", 32'(cnt_b), 32'(i));
        tick();
        if (i * 3 + k < 95) check("s3_done_early", 32'(done_b), 32'h0);
      end
    end
    check("s3_done", 32'(done_b), 32'h1);
    check("s3_cnt_end", 32'(cnt_b), 32'd32);
    check("s3_sig", 32'(sig_b), 32'(GOLD));
    check("s3_pass", 32'(pass_b), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
